// File: rtl/cmd_issue_fifo_pkg.sv
// Shared types and constants for the command issue FIFO.
// Provides the scheduler command encoding, the packed FIFO entry layout
// {cmd, addr, bank}, and the default DRAM timing constants.
package cmd_issue_fifo_pkg;

   localparam int unsigned CMD_BITS       = 4;
   localparam int unsigned ADDR_BITS      = 13;
   localparam int unsigned BA_BITS        = 3;
   localparam int unsigned ISU_FIFO_WIDTH = CMD_BITS + ADDR_BITS + BA_BITS;
   localparam int unsigned TMR_BITS       = 8;

   localparam int unsigned DEF_DEPTH = 8;
   localparam int unsigned DEF_T_RCD = 4;
   localparam int unsigned DEF_T_RP  = 4;
   localparam int unsigned DEF_T_CCD = 2;
   localparam int unsigned DEF_T_RFC = 16;
   localparam int unsigned DEF_T_APR = 8;

   typedef enum logic [CMD_BITS-1:0] {
      ATCMD_NOP       = 4'd0,
      ATCMD_ACTIVE    = 4'd1,
      ATCMD_READ      = 4'd2,
      ATCMD_WRITE     = 4'd3,
      ATCMD_PRECHARGE = 4'd4,
      ATCMD_PREA      = 4'd5,
      ATCMD_RDA       = 4'd6,
      ATCMD_WRA       = 4'd7,
      ATCMD_REFRESH   = 4'd8
   } sch_cmd_t;

   typedef struct packed {
      sch_cmd_t             cmd;
      logic [ADDR_BITS-1:0] addr;
      logic [BA_BITS-1:0]   bank;
   } isu_entry_t;

endpackage

// File: rtl/isu_timing_gate.sv
// Inter-command timing gate for the issue FIFO head.
// Ports: clk/rst_n; head_cmd = command at the FIFO head; issue = head is
// popped this edge; gate_open = head command's timing constraints are met
// (combinational from the counters).
module isu_timing_gate
   import cmd_issue_fifo_pkg::*;
#(
   parameter int unsigned T_RCD = DEF_T_RCD,
   parameter int unsigned T_RP  = DEF_T_RP,
   parameter int unsigned T_CCD = DEF_T_CCD,
   parameter int unsigned T_RFC = DEF_T_RFC,
   parameter int unsigned T_APR = DEF_T_APR
) (
   input  logic     clk,
   input  logic     rst_n,
   input  sch_cmd_t head_cmd,
   input  logic     issue,
   output logic     gate_open
);

   localparam logic [TMR_BITS-1:0] RCD_LD = TMR_BITS'(T_RCD - 1);
   localparam logic [TMR_BITS-1:0] RP_LD  = TMR_BITS'(T_RP - 1);
   localparam logic [TMR_BITS-1:0] CCD_LD = TMR_BITS'(T_CCD - 1);
   localparam logic [TMR_BITS-1:0] RFC_LD = TMR_BITS'(T_RFC - 1);
   localparam logic [TMR_BITS-1:0] APR_LD = TMR_BITS'(T_APR - 1);

   logic [TMR_BITS-1:0] act_wait_q, act_wait_d;
   logic [TMR_BITS-1:0] col_wait_q, col_wait_d;
   logic [TMR_BITS-1:0] any_wait_q, any_wait_d;

   function automatic logic [TMR_BITS-1:0] dec_sat(input logic [TMR_BITS-1:0] v);
      return (v == '0) ? '0 : v - TMR_BITS'(1);
   endfunction

   function automatic logic [TMR_BITS-1:0] max_t(input logic [TMR_BITS-1:0] a,
                                                 input logic [TMR_BITS-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Countdown every cycle; an issued command raises a counter to its
   // constraint only if that is longer than what is already pending.
   always_comb begin
      act_wait_d = dec_sat(act_wait_q);
      col_wait_d = dec_sat(col_wait_q);
      any_wait_d = dec_sat(any_wait_q);
      if (issue) begin
         case (head_cmd)
            ATCMD_ACTIVE: col_wait_d = max_t(col_wait_d, RCD_LD);
            ATCMD_READ, ATCMD_WRITE: col_wait_d = max_t(col_wait_d, CCD_LD);
            ATCMD_RDA, ATCMD_WRA: begin
               col_wait_d = max_t(col_wait_d, CCD_LD);
               act_wait_d = max_t(act_wait_d, APR_LD);
            end
            ATCMD_PRECHARGE, ATCMD_PREA: act_wait_d = max_t(act_wait_d, RP_LD);
            ATCMD_REFRESH: any_wait_d = max_t(any_wait_d, RFC_LD);
            default: ;
         endcase
      end
   end

   // Per-class gate decode for the head command.
   always_comb begin
      gate_open = 1'b0;
      case (head_cmd)
         ATCMD_ACTIVE, ATCMD_REFRESH:
            gate_open = (act_wait_q == '0) && (any_wait_q == '0);
         ATCMD_READ, ATCMD_WRITE, ATCMD_RDA, ATCMD_WRA:
            gate_open = (col_wait_q == '0) && (any_wait_q == '0);
         ATCMD_PRECHARGE, ATCMD_PREA:
            gate_open = (any_wait_q == '0);
         default: gate_open = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_wait_q <= '0;
         col_wait_q <= '0;
         any_wait_q <= '0;
      end else begin
         act_wait_q <= act_wait_d;
         col_wait_q <= col_wait_d;
         any_wait_q <= any_wait_d;
      end
   end

endmodule

// File: rtl/cmd_issue_fifo.sv
// In-order command issue FIFO between the scheduler and the DRAM command bus.
// Ports: clk/rst_n; sch_issue/sch_out = scheduler push of {cmd, addr, bank};
// isu_fifo_full/isu_fifo_empty = occupancy flags (combinational from count);
// dram_cmd_valid/dram_cmd/dram_addr/dram_bank = registered command bus,
// NOP whenever the head is absent or still timing-blocked.
module cmd_issue_fifo
   import cmd_issue_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned T_RCD = DEF_T_RCD,
   parameter int unsigned T_RP  = DEF_T_RP,
   parameter int unsigned T_CCD = DEF_T_CCD,
   parameter int unsigned T_RFC = DEF_T_RFC,
   parameter int unsigned T_APR = DEF_T_APR
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sch_issue,
   input  logic [ISU_FIFO_WIDTH-1:0] sch_out,
   output logic                      isu_fifo_full,
   output logic                      isu_fifo_empty,
   output logic                      dram_cmd_valid,
   output logic [CMD_BITS-1:0]       dram_cmd,
   output logic [ADDR_BITS-1:0]      dram_addr,
   output logic [BA_BITS-1:0]        dram_bank
);

   localparam int unsigned PTR_BITS = $clog2(DEPTH);
   localparam int unsigned CNT_BITS = PTR_BITS + 1;

   isu_entry_t mem [DEPTH];

   logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]  count_q, count_d;
   logic                 valid_q, valid_d;
   sch_cmd_t             cmd_q, cmd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [BA_BITS-1:0]   bank_q, bank_d;

   isu_entry_t push_entry;
   isu_entry_t head_entry;
   logic       push;
   logic       pop;
   logic       gate_open;

   assign push_entry = isu_entry_t'(sch_out);
   assign head_entry = mem[rd_ptr_q];

   assign isu_fifo_full  = (count_q == CNT_BITS'(DEPTH));
   assign isu_fifo_empty = (count_q == '0);

   // Full is taken from the current count, so a pop does not make room
   // for a same-cycle push; NOPs are never stored.
   assign push = sch_issue && !isu_fifo_full && (push_entry.cmd != ATCMD_NOP);
   assign pop  = !isu_fifo_empty && gate_open;

   isu_timing_gate #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_CCD (T_CCD),
      .T_RFC (T_RFC),
      .T_APR (T_APR)
   ) u_gate (
      .clk       (clk),
      .rst_n     (rst_n),
      .head_cmd  (head_entry.cmd),
      .issue     (pop),
      .gate_open (gate_open)
   );

   // Pointer, occupancy and command-bus next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = 1'b0;
      cmd_d    = ATCMD_NOP;
      addr_d   = addr_q;
      bank_d   = bank_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
         valid_d  = 1'b1;
         cmd_d    = head_entry.cmd;
         addr_d   = head_entry.addr;
         bank_d   = head_entry.bank;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_BITS'(1);
         2'b01:   count_d = count_q - CNT_BITS'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         cmd_q    <= ATCMD_NOP;
         addr_q   <= '0;
         bank_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         bank_q   <= bank_d;
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_entry;
      end
   end

   assign dram_cmd_valid = valid_q;
   assign dram_cmd       = cmd_q;
   assign dram_addr      = addr_q;
   assign dram_bank      = bank_q;

endmodule
